// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, req/ack fetch from instruction memory,
// held instruction for the decoder and next-PC selection (JR / J / branch / +4).
// Fetch is non-speculative: a new request goes out only after decode consumes
// the held word, so at most one instruction is in flight.
// Optional build macro: IF_MISALIGN_TRAP_EN -- when defined, a consumed redirect
// to a non-word-aligned address raises fetch_fault and parks the stage in HALT.
// When undefined, the low two bits of the next PC are cleared instead.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_HALT   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] branch_offset;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;
  logic        misaligned;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Redirect selection: JR beats J beats taken branch beats sequential.
  always_comb begin
    next_pc_raw = pc_plus4;
    if (jump_reg) begin
      next_pc_raw = jr_target;
    end else if (jump) begin
      next_pc_raw = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && branch_taken) begin
      next_pc_raw = pc_plus4 + branch_offset;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // Misaligned targets are trapped rather than silently repaired.
  assign misaligned  = |next_pc_raw[1:0];
  assign next_pc     = next_pc_raw;
  assign fetch_fault = (state_q == S_HALT);
`else
  // Only JR can carry low bits; clear them so the PC always stays word aligned.
  assign misaligned  = 1'b0;
  assign next_pc     = {next_pc_raw[31:2], next_pc_raw[1:0] & 2'b00};
  assign fetch_fault = 1'b0;
`endif

  // Request is suppressed while reset is held so nothing leaks out before release.
  assign imem_req    = (state_q == S_FETCH) && !reset;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_DECODE);
  assign pc          = pc_q;

  // Next-state logic: capture on ack in FETCH, advance PC on consume in DECODE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!stall) begin
          if (misaligned) begin
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a driver plays instruction memory and decoder, pushing
// expected fetch addresses and expected held instructions into queues; an
// independent monitor pops and compares whenever the DUT starts a request or
// presents a new instruction. Follows IF_MISALIGN_TRAP_EN if defined.
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          N_RAND = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        jump;
  logic        jump_reg;
  logic        branch;
  logic        branch_taken;
  logic [31:0] jr_target;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .jump(jump), .jump_reg(jump_reg),
    .branch(branch), .branch_taken(branch_taken),
    .jr_target(jr_target), .fetch_fault(fetch_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    int          stalls;
    bit          jr;
    bit          j;
    bit          br;
    bit          bt;
    logic [31:0] tgt;
  } dir_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] addr_exp_q[$];
  exp_t        instr_exp_q[$];
  bit          mon_en     = 1'b0;
  bit          halted_exp = 1'b0;
  bit          prev_req   = 1'b0;
  bit          prev_valid = 1'b0;
  logic [31:0] cur_pc    = 32'd0;
  logic [31:0] cur_instr = 32'd0;
  dir_t        dir[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference next-PC from the architectural rules (before alignment handling).
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input bit jr, input bit j, input bit br, input bit bt,
                                           input logic [31:0] tgt);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = cur + 32'd4;
    off = {{16{word[15]}}, word[15:0]};
    if (jr) return tgt;
    if (j) return (p4 & 32'hF000_0000) | ({6'd0, word[25:0]} << 2);
    if (br && bt) return p4 + off * 32'd4;
    return p4;
  endfunction

  // Monitor: compares DUT outputs against queued expectations, just after each negedge.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (imem_req && !prev_req) begin
        if (addr_exp_q.size() == 0) begin
          check("unexpected_req", 32'(imem_req), 32'd0);
        end else begin
          check("imem_addr", imem_addr, addr_exp_q.pop_front());
        end
      end
      if (imem_req) check("req_and_valid", 32'(instr_valid), 32'd0);
      if (instr_valid && !prev_valid) begin
        if (instr_exp_q.size() == 0) begin
          check("unexpected_valid", 32'(instr_valid), 32'd0);
        end else begin
          exp_t e;
          e = instr_exp_q.pop_front();
          cur_pc    = e.pc;
          cur_instr = e.word;
          check("instr", instr, e.word);
          check("pc", pc, e.pc);
          check("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end else if (instr_valid) begin
        check("instr_hold", instr, cur_instr);
        check("pc_hold", pc, cur_pc);
      end
      check("fetch_fault", 32'(fetch_fault), 32'(halted_exp));
    end
    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] model_pc;
    bit          done;
    dir[0] = '{32'h2008_0005, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    dir[1] = '{32'h0810_0004, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    dir[2] = '{32'h1000_FFFC, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0};
    dir[3] = '{32'h0810_0004, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    dir[4] = '{32'h1000_FFFC, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
    dir[5] = '{32'h0000_0000, 5, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    dir[6] = '{32'h0000_0000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0102};
    dir[7] = '{32'h0000_0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0000};
    dir[8] = '{32'h0810_0010, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};

    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    stall = 1'b0; jump = 1'b0; jump_reg = 1'b0; branch = 1'b0; branch_taken = 1'b0;
    jr_target = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    addr_exp_q.push_back(RST_PC);
    model_pc = RST_PC;
    reset = 1'b0; imem_ack = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    done = 1'b0;
    for (int t = 0; t < 9 + N_RAND && !done; t++) begin
      logic [31:0] word, tgt, nxt;
      int          dly, stalls, w;
      bit          jr, j, br, bt;
      if (t < 9) begin
        word = dir[t].word; stalls = dir[t].stalls; dly = 0;
        jr = dir[t].jr; j = dir[t].j; br = dir[t].br; bt = dir[t].bt; tgt = dir[t].tgt;
      end else begin
        int r;
        word = $urandom; stalls = $urandom_range(0, 3); dly = $urandom_range(0, 3);
        tgt = $urandom; r = $urandom_range(0, 7);
        jr = 1'b0; j = 1'b0; br = 1'b0; bt = 1'b0;
        case (r)
          0: begin jr = 1'b1; j = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1)); bt = 1'($urandom_range(0, 1)); end
          1: begin j = 1'b1; br = 1'($urandom_range(0, 1)); bt = 1'($urandom_range(0, 1)); end
          2, 3: begin br = 1'b1; bt = 1'b1; end
          4: begin br = 1'b1; bt = 1'b0; end
          default: bt = 1'($urandom_range(0, 1));
        endcase
      end

      w = 0;
      while (!imem_req && w < 20) begin @(negedge clk); w++; end
      if (!imem_req) begin
        check("req_timeout", 32'(imem_req), 32'd1);
        done = 1'b1;
      end else begin
        repeat (dly) begin
          imem_ack = 1'b0; imem_rdata = $urandom;
          @(negedge clk);
        end
        imem_ack = 1'b1; imem_rdata = word;
        instr_exp_q.push_back('{model_pc, word});
        @(negedge clk);
        check("valid_latency", 32'(instr_valid), 32'd1);

        // Stall phase: redirects and stray acks must have no effect.
        repeat (stalls) begin
          stall = 1'b1;
          jump = (t < 9) ? 1'b1 : 1'($urandom_range(0, 1));
          jump_reg = 1'($urandom_range(0, 1)); branch = 1'($urandom_range(0, 1));
          branch_taken = 1'($urandom_range(0, 1)); jr_target = $urandom;
          imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
          @(negedge clk);
          check("stall_no_req", 32'(imem_req), 32'd0);
        end

        stall = 1'b0; jump_reg = jr; jump = j; branch = br; branch_taken = bt; jr_target = tgt;
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        nxt = ref_next(model_pc, word, jr, j, br, bt, tgt);
`ifdef IF_MISALIGN_TRAP_EN
        if (nxt[1:0] != 2'b00) begin
          @(negedge clk);
          halted_exp = 1'b1;
          jump = 1'b0; jump_reg = 1'b0; branch = 1'b0; branch_taken = 1'b0;
          imem_ack = 1'b1;
          repeat (3) begin
            check("halt_no_req", 32'(imem_req), 32'd0);
            check("halt_valid", 32'(instr_valid), 32'd0);
            check("halt_pc", pc, model_pc);
            @(negedge clk);
          end
          $display("txn %0d pc=%h instr=%h halted target=%h", t, model_pc, word, nxt);
          done = 1'b1;
        end
`else
        nxt = nxt & 32'hFFFF_FFFC;
`endif
        if (!done) begin
          addr_exp_q.push_back(nxt);
          $display("txn %0d pc=%h instr=%h jr=%0d j=%0d br=%0d bt=%0d stalls=%0d next=%h",
                   t, model_pc, word, jr, j, br, bt, stalls, nxt);
          model_pc = nxt;
          @(negedge clk);
          jump = 1'b0; jump_reg = 1'b0; branch = 1'b0; branch_taken = 1'b0;
          imem_ack = 1'b0;
          check("refetch_latency", 32'(imem_req), 32'd1);
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
